// File: rtl/uart_pkg.sv
// Shared state encoding, widths and source indices for the UART transmit scheduler.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_BUSY,
        ST_GAP
    } tx_state_e;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned ERR_W       = 8;

    localparam int unsigned SRC_KEY  = 0;
    localparam int unsigned SRC_ECHO = 1;
    localparam int unsigned SRC_STAT = 2;

    // Error count sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid source after ptr, wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int unsigned N_REQ = 3
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [1:0]       ptr,
    output logic [N_REQ-1:0] grant,
    output logic [1:0]       idx,
    output logic             any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Pass 0 scans the sources above ptr, pass 1 wraps to those at or below it.
        for (int unsigned pass = 0; pass < 2; pass++) begin
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!any && ((pass == 0) == (j > 32'(ptr)))
                    && (|(valid & (N_REQ'(1) << j)))) begin
                    any   = 1'b1;
                    grant = N_REQ'(1) << j;
                    idx   = 2'(j);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between N_REQ byte sources: round-robin grant, start pulse,
// busy supervision with start/busy timeouts, and a fixed idle gap between bytes.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ    = 3,
    parameter int unsigned DATA_W   = UART_DATA_W,
    parameter int unsigned START_TO = 16,
    parameter int unsigned BUSY_TO  = 16383,
    parameter int unsigned GAP_CYC  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*DATA_W-1:0] i_req_data,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic                    o_tx_start,
    output logic [DATA_W-1:0]       o_tx_data,
    input  logic                    i_tx_busy,
    output logic [1:0]              o_grant_id,
    output logic                    o_active,
    output logic                    o_err_pulse,
    output logic [ERR_W-1:0]        o_err_cnt
);

    localparam int unsigned      CNT_W     = $clog2(BUSY_TO + 1);
    localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TO - 1);
    localparam logic [CNT_W-1:0] BUSY_LIM  = CNT_W'(BUSY_TO - 1);
    localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'(GAP_CYC - 1);

    tx_state_e         state;
    logic [1:0]        ptr;
    logic [CNT_W-1:0]  cnt;
    logic [N_REQ-1:0]  arb_grant;
    logic [1:0]        arb_idx;
    logic              arb_any;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .valid (i_req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign o_req_ready = (state == ST_IDLE) ? arb_grant : '0;
    assign sel_data    = DATA_W'(i_req_data >> (32'(arb_idx) * DATA_W));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            ptr         <= 2'(N_REQ - 1);
            cnt         <= '0;
            o_tx_start  <= 1'b0;
            o_tx_data   <= '0;
            o_grant_id  <= '0;
            o_active    <= 1'b0;
            o_err_pulse <= 1'b0;
            o_err_cnt   <= '0;
        end else begin
            o_tx_start  <= 1'b0;
            o_err_pulse <= 1'b0;
            cnt         <= cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        o_tx_data  <= sel_data;
                        o_grant_id <= arb_idx;
                        ptr        <= arb_idx;
                        o_tx_start <= 1'b1;
                        o_active   <= 1'b1;
                        cnt        <= '0;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    cnt   <= '0;
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        cnt   <= '0;
                        state <= ST_BUSY;
                    end else if (cnt == START_LIM) begin
                        o_err_pulse <= 1'b1;
                        o_err_cnt   <= sat_inc(o_err_cnt);
                        cnt         <= '0;
                        state       <= ST_GAP;
                    end
                end
                ST_BUSY: begin
                    if (!i_tx_busy) begin
                        cnt   <= '0;
                        state <= ST_GAP;
                    end else if (cnt == BUSY_LIM) begin
                        o_err_pulse <= 1'b1;
                        o_err_cnt   <= sat_inc(o_err_cnt);
                        cnt         <= '0;
                        state       <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LIM) begin
                        o_active <= 1'b0;
                        cnt      <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    o_active <= 1'b0;
                    cnt      <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomised scoreboard bench for uart_tx_sched with a queue-based round-robin reference model.
module tb_uart_tx_sched;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [2:0]  i_req_valid;
    logic [23:0] i_req_data;
    logic [2:0]  o_req_ready;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        i_tx_busy;
    logic [1:0]  o_grant_id;
    logic        o_active;
    logic        o_err_pulse;
    logic [7:0]  o_err_cnt;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .N_REQ    (3),
        .DATA_W   (8),
        .START_TO (16),
        .BUSY_TO  (100),
        .GAP_CYC  (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .o_req_ready (o_req_ready),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .i_tx_busy   (i_tx_busy),
        .o_grant_id  (o_grant_id),
        .o_active    (o_active),
        .o_err_pulse (o_err_pulse),
        .o_err_cnt   (o_err_cnt)
    );

    typedef enum int {B_NONE, B_FIXED, B_RAND, B_STUCK} bmode_e;

    int          tests = 0;
    int          failed = 0;
    int          cyc = 0;
    logic [7:0]  q0[$], q1[$], q2[$];
    logic [9:0]  exp_q[$];
    logic        sb_en = 1'b0;
    logic [2:0]  hs = '0;
    logic        hs_any_prev = 1'b0;
    logic        start_seen = 1'b0;
    int          rdy1_cnt = 0;
    int          fall_cyc = 0;
    bmode_e      bmode = B_NONE;
    int          busy_d = 3;
    int          busy_l = 60;
    int          cd = 0;
    int          bl = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic report_fail(input string name, input string why);
        tests++;
        failed++;
        $display("FAIL %s: %s", name, why);
    endtask

    task automatic push_src(input int k, input logic [7:0] v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    // Source drivers and TX busy model, updated just after each rising edge.
    initial begin
        i_req_valid = '0;
        i_req_data  = '0;
        i_tx_busy   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hs[0] && q0.size() != 0) void'(q0.pop_front());
            if (hs[1] && q1.size() != 0) void'(q1.pop_front());
            if (hs[2] && q2.size() != 0) void'(q2.pop_front());
            i_req_valid = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
            i_req_data  = {(q2.size() != 0) ? q2[0] : 8'h00,
                           (q1.size() != 0) ? q1[0] : 8'h00,
                           (q0.size() != 0) ? q0[0] : 8'h00};
            case (bmode)
                B_NONE: begin
                    i_tx_busy = 1'b0;
                    cd = 0;
                    bl = 0;
                end
                B_STUCK: i_tx_busy = 1'b1;
                default: begin
                    if (start_seen)
                        cd = (bmode == B_RAND) ? int'($urandom_range(4, 1)) : busy_d;
                    if (cd > 0) begin
                        cd--;
                        if (cd == 0) begin
                            i_tx_busy = 1'b1;
                            bl = (bmode == B_RAND) ? int'($urandom_range(20, 2)) : busy_l;
                        end
                    end else if (bl > 0) begin
                        bl--;
                        if (bl == 0) begin
                            i_tx_busy = 1'b0;
                            fall_cyc  = cyc;
                        end
                    end
                end
            endcase
        end
    end

    // Monitor: handshake-to-start latency, ready one-hot, and the scoreboard.
    initial begin : mon
        logic [9:0] item;
        forever begin
            @(negedge clk);
            start_seen = o_tx_start;
            if (o_req_ready[1]) rdy1_cnt++;
            if (hs_any_prev)
                check("start_after_handshake", 32'(o_tx_start), 1);
            else if (o_tx_start)
                report_fail("start_without_handshake", "o_tx_start high with no accepted byte");
            if (|o_req_ready)
                check("ready_onehot", $countones(o_req_ready), 1);
            if (sb_en && o_tx_start) begin
                if (exp_q.size() == 0) begin
                    report_fail("sb_unexpected_start", "start with empty expectation queue");
                end else begin
                    item = exp_q.pop_front();
                    check("sb_grant_id", 32'(o_grant_id), 32'(item[9:8]));
                    check("sb_tx_data", 32'(o_tx_data), 32'(item[7:0]));
                end
            end
            hs = i_rst ? 3'b000 : (i_req_valid & o_req_ready);
            hs_any_prev = |hs;
        end
    end

    task automatic do_reset();
        sb_en = 1'b0;
        exp_q.delete();
        q0.delete();
        q1.delete();
        q2.delete();
        bmode = B_NONE;
        @(posedge clk); #1; i_rst = 1'b1;
        @(posedge clk); #1; i_rst = 1'b0;
        @(negedge clk);
    endtask

    // which: 0 = o_tx_start, 1 = o_err_pulse, 2 = o_active low.
    task automatic wait_for(input int which, input int bound, input string name, output int at);
        logic s;
        at = -1;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            s = (which == 0) ? o_tx_start : (which == 1) ? o_err_pulse : !o_active;
            if (s) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) report_fail(name, $sformatf("no event within %0d cycles", bound));
    endtask

    task automatic wait_drain(input string name, input int bound);
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !o_active) break;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 0);
    endtask

    // Reference: every loaded source stays valid until empty, so the grant order is a
    // plain round-robin walk over the non-empty queues starting after source N_REQ-1.
    task automatic load_random();
        logic [7:0] b[3][6];
        int n[3];
        int pos[3];
        int last;
        int k;
        bit found;
        for (int s = 0; s < 3; s++) begin
            n[s]   = int'($urandom_range(6, 0));
            pos[s] = 0;
            for (int i = 0; i < n[s]; i++) begin
                b[s][i] = 8'($urandom);
                push_src(s, b[s][i]);
            end
        end
        last = 2;
        for (int step = 0; step < 18; step++) begin
            found = 1'b0;
            for (int off = 1; off <= 3 && !found; off++) begin
                k = (last + off) % 3;
                if (pos[k] < n[k]) begin
                    exp_q.push_back({2'(k), b[k][pos[k]]});
                    pos[k]++;
                    last  = k;
                    found = 1'b1;
                end
            end
        end
    endtask

    initial begin : main
        int s, e, t, s2, n, first_s, first_e, n_start, n_act;
        i_rst = 1'b1;

        // 1: reset state and quiet idle
        do_reset();
        check("rst_ready", 32'(o_req_ready), 0);
        check("rst_tx_start", 32'(o_tx_start), 0);
        check("rst_tx_data", 32'(o_tx_data), 0);
        check("rst_grant_id", 32'(o_grant_id), 0);
        check("rst_active", 32'(o_active), 0);
        check("rst_err_pulse", 32'(o_err_pulse), 0);
        check("rst_err_cnt", 32'(o_err_cnt), 0);
        n_start = 0;
        n_act = 0;
        repeat (100) begin
            @(negedge clk);
            n_start += int'(o_tx_start);
            n_act   += int'(o_active);
        end
        check("idle_starts", n_start, 0);
        check("idle_active", n_act, 0);

        // 2: single byte from the echo source, busy held below the bench's BUSY_TO of 100
        do_reset();
        bmode = B_FIXED;
        busy_d = 3;
        busy_l = 60;
        rdy1_cnt = 0;
        push_src(SRC_ECHO, 8'h58);
        wait_for(0, 50, "t2_start", s);
        check("t2_tx_data", 32'(o_tx_data), 32'h58);
        check("t2_grant_id", 32'(o_grant_id), SRC_ECHO);
        check("t2_active", 32'(o_active), 1);
        wait_for(2, 200, "t2_idle", t);
        check("t2_idle_cycle", t, fall_cyc + 5);
        check("t2_ready1_cycles", rdy1_cnt, 1);
        check("t2_data_held", 32'(o_tx_data), 32'h58);
        check("t2_err_cnt", 32'(o_err_cnt), 0);

        // 3: all three sources backlogged -> strict 0,1,2,0,1,2
        do_reset();
        bmode = B_FIXED;
        busy_d = 2;
        busy_l = 10;
        sb_en = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 3; k++) begin
                exp_q.push_back({2'(k), 8'(k + 1)});
                push_src(k, 8'(k + 1));
            end
        wait_drain("t3", 500);

        // 4: busy never rises -> start timeout, then next grant after the gap
        do_reset();
        push_src(SRC_ECHO, 8'hA5);
        push_src(SRC_STAT, 8'h5A);
        wait_for(0, 50, "t4_start", s);
        wait_for(1, 50, "t4_err", e);
        check("t4_err_delay", e - s, 17);
        check("t4_err_cnt", 32'(o_err_cnt), 1);
        @(negedge clk);
        check("t4_err_pulse_width", 32'(o_err_pulse), 0);
        wait_for(0, 50, "t4_next_start", s2);
        check("t4_next_start_delay", s2 - e, 5);
        check("t4_next_grant", 32'(o_grant_id), SRC_STAT);

        // 5: busy stuck high -> busy timeout, counter saturation
        do_reset();
        bmode = B_STUCK;
        for (int i = 0; i < 310; i++) push_src(SRC_KEY, 8'(i));
        first_s = -1;
        first_e = -1;
        n = 0;
        for (int c = 0; c < 36000 && n < 300; c++) begin
            @(negedge clk);
            if (o_tx_start && first_s < 0) first_s = cyc;
            if (o_err_pulse) begin
                n++;
                if (first_e < 0) first_e = cyc;
                if (n == 10)  check("t5_err_cnt_10", 32'(o_err_cnt), 10);
                if (n == 255) check("t5_err_cnt_255", 32'(o_err_cnt), 32'hFF);
                if (n == 300) check("t5_err_cnt_300", 32'(o_err_cnt), 32'hFF);
            end
        end
        check("t5_busy_timeout", first_e - first_s, 102);
        check("t5_pulses", n, 300);

        // 6: reset while in BUSY, then pointer must favour source 0 again
        do_reset();
        bmode = B_FIXED;
        busy_d = 3;
        busy_l = 60;
        push_src(SRC_ECHO, 8'h66);
        wait_for(0, 50, "t6_start", s);
        repeat (10) @(negedge clk);
        check("t6_active_before_rst", 32'(o_active), 1);
        do_reset();
        check("t6_active", 32'(o_active), 0);
        check("t6_tx_start", 32'(o_tx_start), 0);
        check("t6_tx_data", 32'(o_tx_data), 0);
        check("t6_grant_id", 32'(o_grant_id), 0);
        check("t6_err_cnt", 32'(o_err_cnt), 0);
        bmode = B_FIXED;
        busy_d = 2;
        busy_l = 5;
        sb_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({2'(k), 8'(8'h10 + k)});
            push_src(k, 8'(8'h10 + k));
        end
        wait_drain("t6", 300);

        // Randomised rounds against the round-robin reference
        for (int r = 0; r < 4; r++) begin
            do_reset();
            bmode = B_RAND;
            sb_en = 1'b1;
            load_random();
            wait_drain($sformatf("rand%0d", r), 2000);
            check($sformatf("rand%0d_err_cnt", r), 32'(o_err_cnt), 0);
        end

        sb_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
